fft16_bitrev_reorder: RTL and testbench

//   Output reorder stage placed directly downstream of fft_16 (radix-2 DIF delay-feedback, 16-pt).
//   fft_16 emits bins in bit-reversed order. This block converts each frame to natural order (X[0]..X[N-1]).

---
 rtl/fft16_bitrev_reorder.sv | 190 +++++++++++++++++++
 tb/tb_fft16_bitrev_reorder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_bitrev_reorder.sv
// fft16_bitrev_reorder
//   Output reorder stage for the 16-point radix-2 DIF FFT. The FFT emits bins
//   in bit-reversed order; this block converts every frame to natural order
//   (X[0]..X[N-1]) through a ping-pong buffer of 2 banks x N complex words.
//   One bank fills while the other streams out, so the output is gapless.
//
// Parameters
//   WD  real/imag sample width (signed two's complement)
//   N   points per frame, power of 2, >= 4
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   sin_re/sin_im carry a valid bin this cycle
//   in_sof     with in_valid: bit-reversed sample index 0 of a frame (resync)
//   sin_re/im  input bin, bit-reversed order
//   out_valid  sout_re/sout_im valid (registered)
//   out_sof    marks natural-order bin X[0] (registered)
//   sout_re/im output bin, natural order (registered)
//   sync_err   only with REORDER_SYNC_ERR_EN defined: one-cycle pulse when a
//              frame start arrives mid-frame, or when the first sample after
//              a completed frame lacks in_sof (that frame is still accepted)
//
// Configuration macro: REORDER_SYNC_ERR_EN (adds the sync_err output).
`timescale 1ns/1ps

module fft16_bitrev_reorder #(
    parameter int WD = 12,
    parameter int N  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [WD-1:0] sin_re,
    input  logic signed [WD-1:0] sin_im,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic signed [WD-1:0] sout_re,
    output logic signed [WD-1:0] sout_im
`ifdef REORDER_SYNC_ERR_EN
    ,
    output logic                 sync_err
`endif
);

    localparam int LOGN = $clog2(N);

    typedef logic [LOGN-1:0] idx_t;
    typedef enum logic { IDLE, READ } state_t;

    localparam idx_t LAST = idx_t'(N - 1);

    function automatic idx_t bitrev(input idx_t i);
        idx_t r;
        r = '0;
        for (int b = 0; b < LOGN; b++) r[b] = i[LOGN-1-b];
        return r;
    endfunction

    // Ping-pong storage, {re, im} per word. Not reset.
    logic [2*WD-1:0] mem [0:1][0:N-1];

    // Write side state
    idx_t       wcnt;
    logic       wb;
    logic [1:0] full;

    // Read side state
    state_t     state;
    logic       rb;
    idx_t       rcnt;

    // ------------------------------------------------------------------
    // Write side: in_sof forces index 0, which silently drops any partial
    // frame already in the current bank (that bank is simply refilled).
    // ------------------------------------------------------------------
    idx_t widx;
    logic wlast;

    always_comb begin
        widx  = in_sof ? '0 : wcnt;
        wlast = in_valid && (widx == LAST);
    end

    always_ff @(posedge clk) begin
        if (in_valid && !rst) mem[wb][bitrev(widx)] <= {sin_re, sin_im};
    end

    // ------------------------------------------------------------------
    // Read side. Leaving IDLE loads X[0] on the same edge, so a bank that
    // becomes FULL on edge T shows X[0] after edge T+1. This also covers a
    // fill completing on the same edge as the last read of the other bank:
    // the read drops to IDLE for zero output cycles and restarts at once.
    // ------------------------------------------------------------------
    logic       pick;       // bank to start from when leaving IDLE
    logic       rd_bank;
    idx_t       rd_idx;
    logic [2*WD-1:0] rd_word;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    logic       rd_last;

    always_comb begin
        pick     = full[0] ? 1'b0 : 1'b1;
        rd_bank  = (state == IDLE) ? pick : rb;
        rd_idx   = (state == IDLE) ? '0 : rcnt;
        rd_word  = mem[rd_bank][rd_idx];
        rd_last  = (state == READ) && (rcnt == LAST);
        full_set = wlast   ? (2'b01 << wb) : 2'b00;
        full_clr = rd_last ? (2'b01 << rb) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt      <= '0;
            wb        <= 1'b0;
            full      <= 2'b00;
            state     <= IDLE;
            rb        <= 1'b0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            sout_re   <= '0;
            sout_im   <= '0;
        end else begin
            if (in_valid) begin
                wcnt <= wlast ? '0 : idx_t'(widx + idx_t'(1));
                if (wlast) wb <= ~wb;
            end

            full <= (full & ~full_clr) | full_set;

            case (state)
                IDLE: begin
                    if (|full) begin
                        state     <= READ;
                        rb        <= pick;
                        rcnt      <= idx_t'(1);
                        out_valid <= 1'b1;
                        out_sof   <= 1'b1;
                        sout_re   <= rd_word[2*WD-1:WD];
                        sout_im   <= rd_word[WD-1:0];
                    end else begin
                        out_valid <= 1'b0;
                        out_sof   <= 1'b0;
                    end
                end
                READ: begin
                    out_valid <= 1'b1;
                    out_sof   <= (rcnt == '0);
                    sout_re   <= rd_word[2*WD-1:WD];
                    sout_im   <= rd_word[WD-1:0];
                    if (rd_last) begin
                        // Other bank already waiting: continue without a bubble.
                        if (full[~rb]) begin
                            rb   <= ~rb;
                            rcnt <= '0;
                        end else begin
                            state <= IDLE;
                            rcnt  <= '0;
                        end
                    end else begin
                        rcnt <= idx_t'(rcnt + idx_t'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REORDER_SYNC_ERR_EN
    // wrap_pend: a frame just completed, so the next valid sample should
    // carry in_sof.
    logic wrap_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err  <= 1'b0;
            wrap_pend <= 1'b0;
        end else if (in_valid) begin
            sync_err  <= (in_sof && (wcnt != '0)) || (!in_sof && wrap_pend);
            wrap_pend <= wlast;
        end else begin
            sync_err  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fft16_bitrev_reorder.sv
`timescale 1ns/1ps

module tb_fft16_bitrev_reorder;

    localparam int WD   = 12;
    localparam int N    = 16;
    localparam int LOGN = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [WD-1:0] sin_re = '0;
    logic [WD-1:0] sin_im = '0;
    logic          out_valid;
    logic          out_sof;
    logic [WD-1:0] sout_re;
    logic [WD-1:0] sout_im;
`ifdef REORDER_SYNC_ERR_EN
    logic          sync_err;
`endif

    fft16_bitrev_reorder #(.WD(WD), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .sin_re    (sin_re),
        .sin_im    (sin_im),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .sout_re   (sout_re),
        .sout_im   (sout_im)
`ifdef REORDER_SYNC_ERR_EN
        ,
        .sync_err  (sync_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard entry: one expected output word and the cycle it must appear.
    typedef struct {
        int            cyc;
        logic [WD-1:0] re;
        logic [WD-1:0] im;
        logic          sof;
    } exp_t;

    exp_t q[$];
    int   errq[$];

    // Reference model of the write side
    int            mw     = 0;
    bit            mwrap  = 1'b0;
    int            last_e = 0;
    logic [WD-1:0] sre [N];
    logic [WD-1:0] sim [N];

    function automatic int brev(input int i);
        int r = 0;
        for (int b = 0; b < LOGN; b++)
            if (((i >> b) & 1) != 0) r |= 1 << (LOGN - 1 - b);
        return r;
    endfunction

    // Drive one cycle; the sample is taken on edge e = cyc+1. A completed
    // frame produces X[n] visible after edge e+1+n.
    task automatic drive(input bit v, input bit sof, input logic [WD-1:0] re, input logic [WD-1:0] im);
        int  e;
        int  idx;
        bit  err;
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = sof;
        sin_re   = re;
        sin_im   = im;
        e = cyc + 1;
        if (v && !rst) begin
            idx   = sof ? 0 : mw;
            err   = (sof && mw != 0) || (!sof && mwrap);
            mwrap = 1'b0;
            sre[idx] = re;
            sim[idx] = im;
            if (idx == N - 1) begin
                for (int n = 0; n < N; n++)
                    q.push_back('{cyc: e + 1 + n, re: sre[brev(n)], im: sim[brev(n)], sof: (n == 0)});
                mw     = 0;
                mwrap  = 1'b1;
                last_e = e;
            end else begin
                mw = idx + 1;
            end
            if (err) errq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'(($urandom() & 1)), WD'($urandom()), WD'($urandom()));
    endtask

    task automatic frame(input int base, input bit sof_first, input int gap);
        for (int k = 0; k < N; k++) begin
            drive(1'b1, sof_first && (k == 0), WD'(base + k), WD'(-(base + k)));
            if (gap > 0) idle(gap);
        end
    endtask

    // Asserts reset now (caller is just past an active edge), discards all
    // pending expectations, holds for ncyc cycles with random inputs.
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        q.delete();
        errq.delete();
        mw    = 0;
        mwrap = 1'b0;
        repeat (ncyc) drive(1'(($urandom() & 1)), 1'(($urandom() & 1)), WD'($urandom()), WD'($urandom()));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        bit   ev;
        exp_t x;
        if (rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_sof",   out_sof,   0);
            check("rst_re",    sout_re,   0);
            check("rst_im",    sout_im,   0);
`ifdef REORDER_SYNC_ERR_EN
            check("rst_sync_err", sync_err, 0);
`endif
        end else begin
            ev = (q.size() > 0) && (q[0].cyc == cyc);
            check("out_valid", out_valid, ev);
            if (ev) begin
                x = q.pop_front();
                if (out_valid) begin
                    check("sout_re", sout_re, x.re);
                    check("sout_im", sout_im, x.im);
                    check("out_sof", out_sof, x.sof);
                end
            end
`ifdef REORDER_SYNC_ERR_EN
            ev = (errq.size() > 0) && (errq[0] == cyc);
            check("sync_err", sync_err, ev);
            if (ev) void'(errq.pop_front());
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        // 1: reset held with random inputs
        rst = 1'b1;
        repeat (3) drive(1'(($urandom() & 1)), 1'(($urandom() & 1)), WD'($urandom()), WD'($urandom()));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(3);

        // 2: single frame, re=k, im=-k
        frame(0, 1'b1, 0);
        idle(30);

        // 3: three back-to-back frames
        frame(0,  1'b1, 0);
        frame(16, 1'b1, 0);
        frame(32, 1'b1, 0);
        idle(40);

        // 4: in_valid every other cycle, two frames
        frame(100, 1'b1, 1);
        frame(150, 1'b1, 1);
        idle(40);

        // 5: resync at wcnt=7, then a full frame
        for (int k = 0; k < 7; k++) drive(1'b1, (k == 0), WD'(900 + k), WD'(k));
        frame(200, 1'b1, 0);
        idle(30);
        // frame following a completed one without in_sof is still accepted
        frame(300, 1'b1, 0);
        frame(320, 1'b0, 0);
        idle(40);

        // 6: reset in the middle of a read
        frame(400, 1'b1, 0);
        guard = 0;
        while (cyc < last_e + 5 && guard < 50) begin
            idle(1);
            guard++;
        end
        check("reset_point_reached", (cyc >= last_e + 5), 1);
        do_reset(2);
        idle(25);
        frame(500, 1'b1, 0);
        idle(30);

        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
